// File: rtl/dense_layer_scheduler.sv
// Time-multiplexed fully-connected layer: one signed DW x DW MAC is shared across all
// N_OUT neurons, streaming weights/biases from external synchronous ROMs.
module dense_layer_scheduler #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 16,
    parameter int DW    = 16,
    parameter int FRAC  = 12,
    parameter int ACC_W = 40
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_IN*DW-1:0]                 in_data,
    output logic [$clog2(N_IN*N_OUT)-1:0]      w_addr,
    input  logic signed [DW-1:0]               w_data,
    output logic [$clog2(N_OUT)-1:0]           b_addr,
    input  logic signed [DW-1:0]               b_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [DW-1:0]               out_data,
    output logic [$clog2(N_OUT)-1:0]           out_idx,
    output logic                               out_last
);

    localparam int KW = $clog2(N_IN);
    localparam int NW = $clog2(N_OUT);
    localparam int AW = $clog2(N_IN*N_OUT);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_FINAL = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
        logic signed [DW-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = v[DW-1:0];
        end
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [NW-1:0]            neuron_q, neuron_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     mac_v_q, mac_v_d;
    logic [KW-1:0]            mac_k_q, mac_k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     x_q [N_IN];
    logic signed [DW-1:0]     x_d [N_IN];
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DW-1:0]     out_data_q, out_data_d;
    logic [NW-1:0]            out_idx_q, out_idx_d;
    logic                     out_last_q, out_last_d;
    logic [AW-1:0]            w_addr_q, w_addr_d;
    logic [NW-1:0]            b_addr_q, b_addr_d;

    logic signed [2*DW-1:0]   prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  bias_ext_s;
    logic signed [ACC_W-1:0]  r_s;

    // w_data always belongs to the address issued one cycle earlier, hence the delayed k index
    assign prod_s     = x_q[mac_k_q] * w_data;
    assign prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
    assign bias_ext_s = {{(ACC_W-DW){b_data[DW-1]}}, b_data};
    assign r_s        = (acc_q >>> FRAC) + bias_ext_s;

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d    = state_q;
        neuron_d   = neuron_q;
        k_d        = k_q;
        x_d        = x_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        mac_v_d    = 1'b0;
        mac_k_d    = k_q;

        if (mac_v_q) begin
            acc_d = acc_q + prod_ext_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < N_IN; i++) begin
                        x_d[i] = in_data[i*DW +: DW];
                    end
                    neuron_d = {NW{1'b0}};
                    k_d      = {KW{1'b0}};
                    acc_d    = {ACC_W{1'b0}};
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                mac_v_d = 1'b1;
                if (k_q == KW'(N_IN-1)) begin
                    k_d     = {KW{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                state_d = S_FINAL;
            end
            S_FINAL: begin
                out_data_d = sat_dw(r_s);
                out_idx_d  = neuron_q;
                out_last_d = (neuron_q == NW'(N_OUT-1));
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        neuron_d = neuron_q + {{(NW-1){1'b0}}, 1'b1};
                        k_d      = {KW{1'b0}};
                        acc_d    = {ACC_W{1'b0}};
                        state_d  = S_RUN;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags and ROM addresses are registered views of the upcoming cycle
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_EMIT);
        w_addr_d    = AW'(neuron_d) * AW'(N_IN) + AW'(k_d);
        b_addr_d    = neuron_d;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            neuron_q    <= {NW{1'b0}};
            k_q         <= {KW{1'b0}};
            mac_v_q     <= 1'b0;
            mac_k_q     <= {KW{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= {DW{1'b0}};
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_idx_q   <= {NW{1'b0}};
            out_last_q  <= 1'b0;
            w_addr_q    <= {AW{1'b0}};
            b_addr_q    <= {NW{1'b0}};
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            k_q         <= k_d;
            mac_v_q     <= mac_v_d;
            mac_k_q     <= mac_k_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;

endmodule

// File: doc/dense_layer_scheduler.md
Name: dense_layer_scheduler

Overview:
- Sequences one shared signed 16x16 MAC to evaluate a fully-connected layer of N_OUT neurons over an N_IN-element Q4.12 input vector, one neuron at a time.
- Fetches weights and biases from external synchronous ROMs.
- Emits one Q4.12 result per neuron over a valid/ready stream.
- Sits between a feature-producing layer and the regression output stage, replacing per-neuron parallel multipliers with one time-multiplexed datapath.

Parameters:
- N_IN, 16, input vector length
- N_OUT, 16, neurons per layer
- DW, 16, data width (Q4.12)
- FRAC, 12, fractional bits
- ACC_W, 40, accumulator width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  scheduler can accept a vector
- in_data  in  DW x N_IN  signed input vector, elements 0..N_IN-1
- w_addr  out  clog2(N_IN*N_OUT)  weight ROM address = neuron*N_IN + k
- w_data  in  DW  signed weight, valid 1 cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias ROM address = neuron index
- b_data  in  DW  signed bias, valid 1 cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  signed Q4.12 neuron result
- out_idx  out  clog2(N_OUT)  neuron index of out_data
- out_last  out  1  high with final neuron (idx N_OUT-1)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; in_ready=1; out_valid=0; out_data=0; out_idx=0; out_last=0; w_addr=0; b_addr=0; accumulator, counters and input register cleared.
- States: IDLE, RUN, DRAIN, FINAL, EMIT.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the internal vector register, clear neuron=0, k=0, acc=0, and go to RUN. in_ready is 0 in every other state.
- RUN (N_IN cycles):
  - Drive w_addr=neuron*N_IN+k and b_addr=neuron; increment k.
  - Each cycle after the first, acc += x[k-1]*w_data, using a registered k delay.
  - After k=N_IN-1 is issued, go to DRAIN.
- DRAIN (1 cycle): accumulate the last product (x[N_IN-1]*w_data).
- FINAL (1 cycle):
  - r = (acc >>> FRAC) + sign_extend(b_data); the shift is arithmetic, rounding toward minus infinity.
  - Saturate r to [-32768, 32767] and register it into out_data.
  - out_idx=neuron; out_last=(neuron==N_OUT-1); go to EMIT.
- EMIT: out_valid=1.
  - out_data, out_idx and out_last hold stable while out_ready=0.
  - On out_ready: if out_last, go to IDLE; else neuron++, k=0, acc=0, go to RUN.
  - out_valid drops in the cycle after the handshake.
- Arithmetic widths:
  - Product: full 32-bit signed.
  - Accumulator: ACC_W bits, sign-extended; it never wraps for N_IN ≤ 256.
  - Saturation applies only at FINAL.
- Latency:
  - First out_valid is asserted N_IN+2 rising edges after the accept edge (18 for defaults).
  - With out_ready held 1, results follow every N_IN+3 cycles (19).
  - A full layer with out_ready=1 takes N_OUT*(N_IN+3) cycles from accept to the last handshake.
- Boundary conditions:
  - in_valid is ignored outside IDLE; the captured vector is unaffected by in_data changes after accept.
  - out_ready high before EMIT has no effect.
  - Reset asserted mid-RUN/EMIT aborts immediately and produces no partial output.
  - After release, the block resumes in IDLE.
- ROM interface: w_data and b_data are sampled exactly one cycle after their address; no ROM stall support.

Test Plan:
- Input x[0]=4096, others 0; w[j][0]=256*j, other weights 0; biases 0 → 16 results, out_data=256*j, out_idx=j, out_last only at j=15, first out_valid 18 cycles after accept.
- All inputs 4096, all weights 4096, bias 0 → sum 65536 saturates: out_data=32767. Repeat with weights -4096 → -32768.
- x[0]=-1, w[*][0]=1, bias 0 → product -1, >>>12 gives -1: out_data=-1 (floor, not truncation toward zero). Then bias 510 → 509.
- Backpressure: hold out_ready=0 for 10 cycles on neuron 3 → out_valid stays 1 and out_data/out_idx stay stable; in_ready stays 0; on release neuron 4 follows 19 cycles later.
- Assert reset during RUN of neuron 5 → all outputs return to reset values immediately; the next vector after release restarts at neuron 0 with correct results.
- Two vectors presented back-to-back with in_valid held high → second accepted only in the cycle after out_last handshake; in_valid during processing is ignored.
